// File: rtl/ibex_wb_queue.sv
// Multi-entry in-order writeback queue between ID/EX and the register file.
// Holds up to Depth instructions, captures in-order LSU responses into their
// entries, retires at most one per cycle and serves forwarding / load-use
// hazard information to the two ID read ports.

package ibex_wb_queue_pkg;
  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'd0,
    WB_INSTR_STORE = 2'd1,
    WB_INSTR_OTHER = 2'd2
  } wb_instr_type_e;
endpackage

module ibex_wb_queue
  import ibex_wb_queue_pkg::*;
#(
  parameter int unsigned  Depth    = 2,
  parameter bit           ResetAll = 1'b0,
  localparam int unsigned OccW     = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_wb_i,
  input  wb_instr_type_e       instr_type_wb_i,
  input  logic [31:0]          pc_id_i,
  input  logic                 instr_is_compressed_id_i,
  input  logic                 instr_perf_count_id_i,
  input  logic [4:0]           rf_waddr_id_i,
  input  logic [31:0]          rf_wdata_id_i,
  input  logic                 rf_we_id_i,
  input  logic                 lsu_resp_valid_i,
  input  logic                 lsu_resp_err_i,
  input  logic [31:0]          rf_wdata_lsu_i,
  input  logic                 rf_we_lsu_i,
  input  logic [4:0]           rf_raddr_a_i,
  input  logic [4:0]           rf_raddr_b_i,
  output logic                 ready_wb_o,
  output logic                 rf_we_wb_o,
  output logic [4:0]           rf_waddr_wb_o,
  output logic [31:0]          rf_wdata_wb_o,
  output logic                 instr_done_wb_o,
  output logic [31:0]          pc_wb_o,
  output logic                 perf_instr_ret_wb_o,
  output logic                 perf_instr_ret_compressed_wb_o,
  output logic                 outstanding_load_wb_o,
  output logic                 outstanding_store_wb_o,
  output logic                 fwd_a_valid_o,
  output logic                 fwd_b_valid_o,
  output logic [31:0]          fwd_a_data_o,
  output logic [31:0]          fwd_b_data_o,
  output logic                 stall_a_o,
  output logic                 stall_b_o,
  output logic [OccW-1:0]      occupancy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  function automatic ptr_t ptr_add(ptr_t p, int unsigned n);
    return ptr_t'((32'(p) + n) % Depth);
  endfunction

  // Control state (always reset)
  logic [Depth-1:0] valid_q, valid_d, done_q, done_d, err_q, err_d;
  ptr_t             head_q, head_d, tail_q, tail_d;
  logic [OccW-1:0]  occ_q, occ_d;

  // Payload state (reset only when ResetAll)
  wb_instr_type_e   type_q  [Depth];
  wb_instr_type_e   type_d  [Depth];
  logic [31:0]      pc_q    [Depth];
  logic [31:0]      pc_d    [Depth];
  logic [31:0]      wdata_q [Depth];
  logic [31:0]      wdata_d [Depth];
  logic [4:0]       waddr_q [Depth];
  logic [4:0]       waddr_d [Depth];
  logic [Depth-1:0] comp_q, comp_d, cnt_q, cnt_d, we_q, we_d;

  logic        tgt_found, bypass, retire, enq, head_valid, head_load, head_err;
  ptr_t        tgt_idx;
  logic [4:0]  raddr;
  logic [1:0]  fwd_valid, stall;
  logic [31:0] fwd_data [2];

  // Locate the response target (oldest unanswered LOAD/STORE) and outstanding flags
  always_comb begin
    tgt_found              = 1'b0;
    tgt_idx                = '0;
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (!tgt_found && valid_q[ptr_add(head_q, i)] && !done_q[ptr_add(head_q, i)] &&
          type_q[ptr_add(head_q, i)] != WB_INSTR_OTHER) begin
        tgt_found = 1'b1;
        tgt_idx   = ptr_add(head_q, i);
      end
      if (valid_q[i] && !done_q[i] && type_q[i] == WB_INSTR_LOAD)  outstanding_load_wb_o  = 1'b1;
      if (valid_q[i] && !done_q[i] && type_q[i] == WB_INSTR_STORE) outstanding_store_wb_o = 1'b1;
    end
  end

  // Head retire decision and RF / perf-counter outputs
  always_comb begin
    head_valid = valid_q[head_q];
    head_load  = type_q[head_q] == WB_INSTR_LOAD;
    bypass     = lsu_resp_valid_i & tgt_found & (tgt_idx == head_q);
    retire     = head_valid & ((type_q[head_q] == WB_INSTR_OTHER) | done_q[head_q] | bypass);
    head_err   = bypass ? lsu_resp_err_i : err_q[head_q];
    ready_wb_o = (occ_q < OccW'(Depth)) | retire;
    enq        = en_wb_i & ready_wb_o;

    rf_we_wb_o      = retire & ((bypass & head_load) ? rf_we_lsu_i : we_q[head_q]);
    rf_waddr_wb_o   = head_valid ? waddr_q[head_q] : '0;
    rf_wdata_wb_o   = !head_valid ? '0 : (bypass & head_load) ? rf_wdata_lsu_i : wdata_q[head_q];
    pc_wb_o         = head_valid ? pc_q[head_q] : '0;
    instr_done_wb_o = retire;
    perf_instr_ret_wb_o            = retire & cnt_q[head_q] & ~head_err;
    perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & comp_q[head_q];
    occupancy_o     = occ_q;
  end

  // Forwarding: later (younger) matches overwrite earlier ones while scanning oldest-first
  always_comb begin
    raddr = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      raddr        = (p == 0) ? rf_raddr_a_i : rf_raddr_b_i;
      fwd_valid[p] = 1'b0;
      stall[p]     = 1'b0;
      fwd_data[p]  = '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        if (valid_q[ptr_add(head_q, i)] && raddr != '0 &&
            waddr_q[ptr_add(head_q, i)] == raddr &&
            (we_q[ptr_add(head_q, i)] || type_q[ptr_add(head_q, i)] == WB_INSTR_LOAD)) begin
          fwd_valid[p] = 1'b0;
          stall[p]     = 1'b0;
          fwd_data[p]  = '0;
          if (type_q[ptr_add(head_q, i)] == WB_INSTR_OTHER ||
              (type_q[ptr_add(head_q, i)] == WB_INSTR_LOAD && done_q[ptr_add(head_q, i)])) begin
            fwd_valid[p] = 1'b1;
            fwd_data[p]  = wdata_q[ptr_add(head_q, i)];
          end else if (type_q[ptr_add(head_q, i)] == WB_INSTR_LOAD) begin
            stall[p] = 1'b1;
          end
        end
      end
    end
    fwd_a_valid_o = fwd_valid[0];
    fwd_b_valid_o = fwd_valid[1];
    fwd_a_data_o  = fwd_data[0];
    fwd_b_data_o  = fwd_data[1];
    stall_a_o     = stall[0];
    stall_b_o     = stall[1];
  end

  // Next state: retire frees the head, response fills its target, enqueue writes the tail.
  // Enqueue is applied last so a full-queue enqueue reusing the retiring head slot wins.
  always_comb begin
    valid_d = valid_q;  done_d = done_q;  err_d  = err_q;
    type_d  = type_q;   pc_d   = pc_q;    wdata_d = wdata_q;  waddr_d = waddr_q;
    comp_d  = comp_q;   cnt_d  = cnt_q;   we_d   = we_q;
    head_d  = head_q;   tail_d = tail_q;
    occ_d   = occ_q + OccW'(enq) - OccW'(retire);
    if (retire) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_add(head_q, 1);
    end
    if (lsu_resp_valid_i && tgt_found) begin
      done_d[tgt_idx] = 1'b1;
      err_d[tgt_idx]  = lsu_resp_err_i;
      if (type_q[tgt_idx] == WB_INSTR_LOAD) begin
        wdata_d[tgt_idx] = rf_wdata_lsu_i;
        we_d[tgt_idx]    = rf_we_lsu_i;
      end
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      err_d[tail_q]   = 1'b0;
      type_d[tail_q]  = instr_type_wb_i;
      pc_d[tail_q]    = pc_id_i;
      comp_d[tail_q]  = instr_is_compressed_id_i;
      cnt_d[tail_q]   = instr_perf_count_id_i;
      we_d[tail_q]    = rf_we_id_i;
      waddr_d[tail_q] = rf_waddr_id_i;
      wdata_d[tail_q] = rf_wdata_id_i;
      tail_d          = ptr_add(tail_q, 1);
    end
  end

  // Control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
    end
  end

  if (ResetAll) begin : g_payload_rst
    // Payload registers with reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        type_q  <= '{default: WB_INSTR_LOAD};
        pc_q    <= '{default: '0};
        wdata_q <= '{default: '0};
        waddr_q <= '{default: '0};
        comp_q  <= '0;
        cnt_q   <= '0;
        we_q    <= '0;
      end else begin
        type_q  <= type_d;
        pc_q    <= pc_d;
        wdata_q <= wdata_d;
        waddr_q <= waddr_d;
        comp_q  <= comp_d;
        cnt_q   <= cnt_d;
        we_q    <= we_d;
      end
    end
  end else begin : g_payload_nrst
    // Payload registers without reset; qualified everywhere by valid bits
    always_ff @(posedge clk_i) begin
      type_q  <= type_d;
      pc_q    <= pc_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      comp_q  <= comp_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  a_we_implies_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rf_we_wb_o |-> instr_done_wb_o);
  a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    occ_q <= OccW'(Depth));
  a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !ready_wb_o |-> !enq);
  a_resp_has_target: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid_i |-> tgt_found);

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Directed bench for ibex_wb_queue: a Depth=2 instance for the main flows and
// a Depth=4 ResetAll instance for multi-entry forwarding and mid-run reset.
module tb_ibex_wb_queue;
  import ibex_wb_queue_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Shared stimulus
  logic rst2_n, rst4_n, en2, en4, resp2;
  wb_instr_type_e ityp;
  logic [31:0] pc, wdata, lsu_data;
  logic [4:0]  waddr, ra, rb;
  logic comp, cnt, we_id, resp_err, lsu_we;
  logic resp4;

  // Depth=2 outputs
  logic ready2, we2, done2, perf2, perfc2, ol2, os2, fav2, fbv2, sa2, sb2;
  logic [4:0]  wa2;
  logic [31:0] wd2, pc2, fad2, fbd2;
  logic [1:0]  occ2;
  // Depth=4 outputs
  logic ready4, we4, done4, perf4, perfc4, ol4, os4, fav4, fbv4, sa4, sb4;
  logic [4:0]  wa4;
  logic [31:0] wd4, pc4, fad4, fbd4;
  logic [2:0]  occ4;

  ibex_wb_queue #(.Depth(2), .ResetAll(1'b0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst2_n), .en_wb_i(en2), .instr_type_wb_i(ityp),
    .pc_id_i(pc), .instr_is_compressed_id_i(comp), .instr_perf_count_id_i(cnt),
    .rf_waddr_id_i(waddr), .rf_wdata_id_i(wdata), .rf_we_id_i(we_id),
    .lsu_resp_valid_i(resp2), .lsu_resp_err_i(resp_err), .rf_wdata_lsu_i(lsu_data),
    .rf_we_lsu_i(lsu_we), .rf_raddr_a_i(ra), .rf_raddr_b_i(rb),
    .ready_wb_o(ready2), .rf_we_wb_o(we2), .rf_waddr_wb_o(wa2), .rf_wdata_wb_o(wd2),
    .instr_done_wb_o(done2), .pc_wb_o(pc2), .perf_instr_ret_wb_o(perf2),
    .perf_instr_ret_compressed_wb_o(perfc2), .outstanding_load_wb_o(ol2),
    .outstanding_store_wb_o(os2), .fwd_a_valid_o(fav2), .fwd_b_valid_o(fbv2),
    .fwd_a_data_o(fad2), .fwd_b_data_o(fbd2), .stall_a_o(sa2), .stall_b_o(sb2),
    .occupancy_o(occ2));

  ibex_wb_queue #(.Depth(4), .ResetAll(1'b1)) u_dut4 (
    .clk_i(clk), .rst_ni(rst4_n), .en_wb_i(en4), .instr_type_wb_i(ityp),
    .pc_id_i(pc), .instr_is_compressed_id_i(comp), .instr_perf_count_id_i(cnt),
    .rf_waddr_id_i(waddr), .rf_wdata_id_i(wdata), .rf_we_id_i(we_id),
    .lsu_resp_valid_i(resp4), .lsu_resp_err_i(resp_err), .rf_wdata_lsu_i(lsu_data),
    .rf_we_lsu_i(lsu_we), .rf_raddr_a_i(ra), .rf_raddr_b_i(rb),
    .ready_wb_o(ready4), .rf_we_wb_o(we4), .rf_waddr_wb_o(wa4), .rf_wdata_wb_o(wd4),
    .instr_done_wb_o(done4), .pc_wb_o(pc4), .perf_instr_ret_wb_o(perf4),
    .perf_instr_ret_compressed_wb_o(perfc4), .outstanding_load_wb_o(ol4),
    .outstanding_store_wb_o(os4), .fwd_a_valid_o(fav4), .fwd_b_valid_o(fbv4),
    .fwd_a_data_o(fad4), .fwd_b_data_o(fbd4), .stall_a_o(sa4), .stall_b_o(sb4),
    .occupancy_o(occ4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic b(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en2 = 1'b0; en4 = 1'b0; resp2 = 1'b0; resp4 = 1'b0;
    resp_err = 1'b0; lsu_we = 1'b0; lsu_data = '0; comp = 1'b0;
  endtask

  task automatic offer(input wb_instr_type_e t, input logic [31:0] p, input logic [4:0] wa,
                       input logic [31:0] wd, input logic we, input logic c);
    ityp = t; pc = p; waddr = wa; wdata = wd; we_id = we; comp = c; cnt = 1'b1;
  endtask

  task automatic resp(input logic [31:0] d, input logic lwe, input logic err);
    resp2 = 1'b1; lsu_data = d; lsu_we = lwe; resp_err = err;
  endtask

  initial begin
    #100000;
    $error("FAIL timeout bench did not complete");
    $fatal(1);
  end

  initial begin
    rst2_n = 1'b0; rst4_n = 1'b0;
    idle();
    offer(WB_INSTR_OTHER, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
    ra = 5'd0; rb = 5'd0;
    #2;
    // Reset state
    b("rst_ready2", ready2, 1'b1);  b("rst_we2", we2, 1'b0);
    b("rst_done2", done2, 1'b0);    b("rst_perf2", perf2, 1'b0);
    b("rst_ol2", ol2, 1'b0);        b("rst_os2", os2, 1'b0);
    b("rst_fav2", fav2, 1'b0);      b("rst_sa2", sa2, 1'b0);
    chk("rst_occ2", 32'(occ2), 32'd0);
    chk("rst_pc2", pc2, 32'd0);
    b("rst_ready4", ready4, 1'b1);
    chk("rst_occ4", 32'(occ4), 32'd0);
    cyc(); cyc();
    rst2_n = 1'b1; rst4_n = 1'b1;
    cyc();

    // Back-to-back OTHER writes
    en2 = 1'b1; offer(WB_INSTR_OTHER, 32'h1000, 5'd5, 32'h11, 1'b1, 1'b0); #2;
    b("t1_c0_we", we2, 1'b0); b("t1_c0_ready", ready2, 1'b1);
    cyc();
    en2 = 1'b1; offer(WB_INSTR_OTHER, 32'h1004, 5'd6, 32'h22, 1'b1, 1'b1); #2;
    b("t1_c1_we", we2, 1'b1); chk("t1_c1_wa", 32'(wa2), 32'd5); chk("t1_c1_wd", wd2, 32'h11);
    chk("t1_c1_pc", pc2, 32'h1000); b("t1_c1_perf", perf2, 1'b1); b("t1_c1_perfc", perfc2, 1'b0);
    chk("t1_c1_occ", 32'(occ2), 32'd1);
    cyc();
    idle(); #2;
    b("t1_c2_we", we2, 1'b1); chk("t1_c2_wa", 32'(wa2), 32'd6); chk("t1_c2_wd", wd2, 32'h22);
    b("t1_c2_perf", perf2, 1'b1); b("t1_c2_perfc", perfc2, 1'b1);
    chk("t1_c2_occ", 32'(occ2), 32'd1);
    cyc(); #2;
    b("t1_c3_we", we2, 1'b0); chk("t1_c3_occ", 32'(occ2), 32'd0);

    // LOAD x7 then OTHER x8, late response
    cyc();
    en2 = 1'b1; offer(WB_INSTR_LOAD, 32'h2000, 5'd7, 32'h0, 1'b1, 1'b0);
    cyc();
    en2 = 1'b1; offer(WB_INSTR_OTHER, 32'h2004, 5'd8, 32'h33, 1'b1, 1'b0);
    ra = 5'd7; rb = 5'd8; #2;
    b("t2_c1_we", we2, 1'b0); b("t2_c1_done", done2, 1'b0); b("t2_c1_ol", ol2, 1'b1);
    b("t2_c1_sa", sa2, 1'b1); b("t2_c1_fav", fav2, 1'b0);
    cyc();
    idle(); #2;
    b("t2_c2_sa", sa2, 1'b1); b("t2_c2_fbv", fbv2, 1'b1); chk("t2_c2_fbd", fbd2, 32'h33);
    chk("t2_c2_occ", 32'(occ2), 32'd2); b("t2_c2_we", we2, 1'b0); b("t2_c2_ready", ready2, 1'b0);
    cyc(); #2;
    b("t2_c3_sa", sa2, 1'b1); b("t2_c3_done", done2, 1'b0);
    cyc();
    resp(32'hDEAD, 1'b1, 1'b0); #2;
    b("t2_c4_we", we2, 1'b1); chk("t2_c4_wa", 32'(wa2), 32'd7); chk("t2_c4_wd", wd2, 32'hDEAD);
    b("t2_c4_done", done2, 1'b1); b("t2_c4_perf", perf2, 1'b1); b("t2_c4_sa", sa2, 1'b1);
    cyc();
    idle(); #2;
    b("t2_c5_we", we2, 1'b1); chk("t2_c5_wa", 32'(wa2), 32'd8); chk("t2_c5_wd", wd2, 32'h33);
    b("t2_c5_sa", sa2, 1'b0); b("t2_c5_fav", fav2, 1'b0); b("t2_c5_ol", ol2, 1'b0);
    b("t2_c5_fbv", fbv2, 1'b1);
    cyc(); #2;
    chk("t2_c6_occ", 32'(occ2), 32'd0); b("t2_c6_fbv", fbv2, 1'b0); chk("t2_c6_fbd", fbd2, 32'd0);
    ra = 5'd0; rb = 5'd0;

    // Full with two LOADs, enqueue held
    cyc();
    en2 = 1'b1; offer(WB_INSTR_LOAD, 32'h3000, 5'd10, 32'h0, 1'b1, 1'b0);
    cyc();
    en2 = 1'b1; offer(WB_INSTR_LOAD, 32'h3004, 5'd11, 32'h0, 1'b1, 1'b0); #2;
    b("t3_c1_ready", ready2, 1'b1);
    cyc();
    en2 = 1'b1; offer(WB_INSTR_OTHER, 32'h3008, 5'd12, 32'h44, 1'b1, 1'b0); #2;
    b("t3_c2_ready", ready2, 1'b0); chk("t3_c2_occ", 32'(occ2), 32'd2);
    cyc(); #2;
    b("t3_c3_ready", ready2, 1'b0); chk("t3_c3_occ", 32'(occ2), 32'd2);
    cyc();
    resp(32'hBEEF, 1'b1, 1'b0); #2;
    b("t3_c4_ready", ready2, 1'b1); b("t3_c4_we", we2, 1'b1);
    chk("t3_c4_wa", 32'(wa2), 32'd10); chk("t3_c4_wd", wd2, 32'hBEEF);
    cyc();
    idle(); #2;
    chk("t3_c5_occ", 32'(occ2), 32'd2); b("t3_c5_we", we2, 1'b0); b("t3_c5_ol", ol2, 1'b1);
    cyc();
    resp(32'hCAFE, 1'b1, 1'b0); #2;
    b("t3_c6_we", we2, 1'b1); chk("t3_c6_wa", 32'(wa2), 32'd11); chk("t3_c6_wd", wd2, 32'hCAFE);
    cyc();
    idle(); #2;
    b("t3_c7_we", we2, 1'b1); chk("t3_c7_wa", 32'(wa2), 32'd12); chk("t3_c7_wd", wd2, 32'h44);
    cyc(); #2;
    chk("t3_c8_occ", 32'(occ2), 32'd0);

    // STORE with bus error
    cyc();
    en2 = 1'b1; offer(WB_INSTR_STORE, 32'h4000, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc();
    idle(); #2;
    b("t4_c1_os", os2, 1'b1); b("t4_c1_done", done2, 1'b0);
    cyc();
    resp(32'h0, 1'b0, 1'b1); #2;
    b("t4_c2_done", done2, 1'b1); b("t4_c2_perf", perf2, 1'b0); b("t4_c2_we", we2, 1'b0);
    cyc();
    idle(); #2;
    b("t4_c3_os", os2, 1'b0); chk("t4_c3_occ", 32'(occ2), 32'd0);

    // Depth=4: LOAD x0 blocks head, two OTHER writes to x9 queue behind it
    cyc();
    en4 = 1'b1; offer(WB_INSTR_LOAD, 32'h5000, 5'd0, 32'h0, 1'b1, 1'b0);
    cyc();
    en4 = 1'b1; offer(WB_INSTR_OTHER, 32'h5004, 5'd9, 32'h1, 1'b1, 1'b0);
    cyc();
    en4 = 1'b1; offer(WB_INSTR_OTHER, 32'h5008, 5'd9, 32'h2, 1'b1, 1'b0);
    ra = 5'd9; rb = 5'd0; #2;
    b("t5_c2_fav", fav4, 1'b1); chk("t5_c2_fad", fad4, 32'h1);
    cyc();
    idle(); #2;
    chk("t5_c3_occ", 32'(occ4), 32'd3); b("t5_c3_fav", fav4, 1'b1); chk("t5_c3_fad", fad4, 32'h2);
    b("t5_c3_fbv", fbv4, 1'b0); b("t5_c3_sb", sb4, 1'b0); b("t5_c3_we", we4, 1'b0);
    b("t5_c3_ol", ol4, 1'b1); b("t5_c3_ready", ready4, 1'b1);

    // Mid-run reset discards all three entries
    rst4_n = 1'b0; #1;
    chk("t6_rst_occ", 32'(occ4), 32'd0); b("t6_rst_ready", ready4, 1'b1);
    b("t6_rst_we", we4, 1'b0); b("t6_rst_fav", fav4, 1'b0);
    cyc();
    rst4_n = 1'b1; #2;
    chk("t6_c1_occ", 32'(occ4), 32'd0); b("t6_c1_ready", ready4, 1'b1);
    b("t6_c1_we", we4, 1'b0); b("t6_c1_done", done4, 1'b0); b("t6_c1_ol", ol4, 1'b0);
    cyc(); #2;
    b("t6_c2_we", we4, 1'b0); chk("t6_c2_pc", pc4, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
